// File: rtl/chain_check_pkg.sv
// Shared types for the launch/capture chain checker: FSM states and the
// "no mismatch seen" index marker.
package chain_check_pkg;

  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

  // Sliced to CNT_W by users; any index width up to 64 is covered.
  localparam logic [63:0] IDX_NONE = '1;

endpackage

// File: rtl/bit_delay_line.sv
// Free-running 1-bit shift line; q is d delayed by exactly DEPTH clocks.
module bit_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/chain_capture_checker.sv
// Capture-side checker: compares buffer and inverter chain outputs against
// the launched bit delayed LAT cycles, over a window of NUM_SAMPLES samples.
module chain_capture_checker
  import chain_check_pkg::*;
#(
  parameter int LAT         = 1,
  parameter int NUM_SAMPLES = 256,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             launch_d,
  input  logic             path_a,
  input  logic             path_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam int               FW        = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [FW-1:0]    FILL_LAST = FW'(LAT - 1);
  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] NONE      = IDX_NONE[CNT_W-1:0];

  state_t           state;
  logic [FW-1:0]    fill_cnt;
  logic [CNT_W-1:0] samp_cnt;
  logic             exp_bit;
  logic             mism;

  bit_delay_line #(.DEPTH(LAT)) u_exp (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (launch_d),
    .q     (exp_bit)
  );

  // Both paths wrong on one sample still counts as a single mismatch.
  assign mism = (path_a != exp_bit) | (path_b != exp_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fill_cnt      <= '0;
      samp_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= NONE;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= FILL;
            fill_cnt      <= '0;
            samp_cnt      <= '0;
            err_cnt       <= '0;
            first_err_idx <= NONE;
            pass          <= 1'b0;
            busy          <= 1'b1;
          end
        end
        FILL: begin
          if (fill_cnt == FILL_LAST) state <= CHECK;
          else                       fill_cnt <= fill_cnt + FW'(1);
        end
        CHECK: begin
          if (mism) begin
            if (err_cnt != CNT_MAX)    err_cnt <= err_cnt + CNT_W'(1);
            if (first_err_idx == NONE) first_err_idx <= samp_cnt;
          end
          if (samp_cnt == SAMP_LAST) state <= DONE;
          else                       samp_cnt <= samp_cnt + CNT_W'(1);
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_cnt == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
